// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the bit-serial adder.
//   state_t : control FSM states (IDLE/RUN/DONE, encoded 0/1/2)
//   maj3    : three-input majority, the carry function of a full adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: single-bit combinational full adder (dataflow).
//   a, b, cin -> sum  : a ^ b ^ cin
//                cout : majority(a, b, cin)
module full_adder
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one bit per clock through a
// single full-adder cell and a carry flip-flop. Rebuilds a minuend from a
// difference and subtrahend (a = diff + b) for round-trip checking.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request, sampled only while idle
//   a_in, b_in, cin : operands and carry-in, captured on an accepted start
//   busy            : high while bits are being processed
//   done            : one-cycle pulse, sum/cout valid
//   sum, cout       : registered result, held until the next completion
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned    CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] w_sum_sr_next;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_done;
  logic             w_s;
  logic             w_c;

  full_adder u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .sum  (w_s),
    .cout (w_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)         w_state_next = ST_RUN;
      ST_RUN:  if (r_cnt == LAST) w_state_next = ST_DONE;
      ST_DONE:                    w_state_next = ST_IDLE;
      default:                    w_state_next = ST_IDLE;
    endcase
  end

  // Shift right and drop the new bit into the MSB; written as a shift plus
  // a bit overwrite so it stays legal when WIDTH is 1.
  always_comb begin
    w_sum_sr_next            = r_sum_sr >> 1;
    w_sum_sr_next[WIDTH-1]   = w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sr   <= a_in;
            r_b_sr   <= b_in;
            r_carry  <= cin;
            r_cnt    <= '0;
            r_sum_sr <= '0;
          end
        end
        ST_RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_sum_sr <= w_sum_sr_next;
          r_carry  <= w_c;
          r_cnt    <= r_cnt + CW'(1);
        end
        ST_DONE: begin
          r_sum  <= r_sum_sr;
          r_cout <= r_carry;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int n_cmp = 0;
  int n_err = 0;
  int n_done8 = 0;
  int n_done1 = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] e8;
  logic [1:0] e1;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumers: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done8) begin
      n_done8++;
      check("excl8", 32'(busy8), 32'd0);
      if (q8.size() == 0) check("spurious_done8", 32'd1, 32'd0);
      else begin
        e8 = q8.pop_front();
        check("sum8", 32'(sum8), 32'(e8[7:0]));
        check("cout8", 32'(cout8), 32'(e8[8]));
      end
    end
    if (done1) begin
      n_done1++;
      check("excl1", 32'(busy1), 32'd0);
      if (q1.size() == 0) check("spurious_done1", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("sum1", 32'(sum1), 32'(e1[0]));
        check("cout1", 32'(cout1), 32'(e1[1]));
      end
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    int busy_n;
    int lat;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk);
    q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
    #1 start8 = 1'b0;
    busy_n = busy8 ? 1 : 0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (busy8) busy_n++;
      if (done8) lat = i;
    end
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
  endtask

  task automatic run1(input logic a, input logic b, input logic c, input logic [1:0] exp, input string tag);
    int busy_n;
    int lat;
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk);
    q1.push_back(exp);
    #1 start1 = 1'b0;
    busy_n = busy1 ? 1 : 0;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (busy1) busy_n++;
      if (done1) lat = i;
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int t1;
    int t2;
    logic d, bo;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_sum8", 32'(sum8), 32'd0);
    check("rst_cout8", 32'(cout8), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_sum1", 32'(sum1), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_busy8", 32'(busy8), 32'd0);
      check("idle_done8", 32'(done8), 32'd0);
    end
    check("idle_sum8", 32'(sum8), 32'd0);
    check("idle_cout8", 32'(cout8), 32'd0);

    // Basic add, wrap and carry cases
    run8(8'h5A, 8'h3C, 1'b0, "basic");
    run8(8'hFF, 8'h01, 1'b0, "wrap1");
    run8(8'hFF, 8'h00, 1'b1, "wrap2");
    run8(8'hFF, 8'hFF, 1'b1, "wrap3");
    for (int i = 0; i < 6; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), "rand");

    // Start while busy is dropped
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    q8.push_back(9'h030);
    base = n_done8;
    #1 start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("busy_start_dones", 32'(n_done8 - base), 32'd1);

    // Start held high re-triggers every WIDTH+2 cycles
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    q8.push_back(9'h047);
    q8.push_back(9'h047);
    @(posedge clk);
    t1 = 0; t2 = 0;
    for (int i = 1; i <= 40 && t2 == 0; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        if (t1 == 0) t1 = i;
        else         t2 = i;
      end
      if (i == 12) start8 = 1'b0;
    end
    start8 = 1'b0;
    check("held_first_done", 32'(t1), 32'd9);
    check("held_second_done", 32'(t2), 32'd19);

    // Reset mid-operation discards the partial result
    repeat (3) @(posedge clk);
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy8", 32'(busy8), 32'd0);
    check("midrst_done8", 32'(done8), 32'd0);
    check("midrst_sum8", 32'(sum8), 32'd0);
    check("midrst_cout8", 32'(cout8), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    base = n_done8;
    repeat (15) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(n_done8 - base), 32'd0);
    run8(8'h0F, 8'h01, 1'b0, "post_rst");

    // Round trip through a full-subtractor model, WIDTH=1, exhaustive
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int bi = 0; bi < 2; bi++) begin
          d  = 1'(a ^ b ^ bi);
          bo = 1'((~a & b) | (~a & bi) | (b & bi));
          run1(d, 1'(b), 1'(bi), {bo, 1'(a)}, "round_trip");
        end

    repeat (4) @(posedge clk);
    #1;
    check("sb8_empty", 32'(q8.size()), 32'd0);
    check("sb1_empty", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
